// File: rtl/bsg_nasti_pkg.sv
// rtl/bsg_nasti_pkg.sv - shared bsg_host link word type and width
package bsg_nasti_pkg;

    localparam int bsg_host_width_p = 32;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [23:0] payload;
    } bsg_host_t;

endpackage

// File: rtl/bsg_two_fifo.sv
// rtl/bsg_two_fifo.sv - two-entry fifo with registered ready and valid
module bsg_two_fifo #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_r [2];
    logic               head_r;
    logic               tail_r;
    logic [1:0]         count_r;
    logic               enq;
    logic               deq;

    // ready_o reflects stored occupancy only, so a dequeue never opens a slot in the same cycle
    assign ready_o = (count_r != 2'd2);
    assign v_o     = (count_r != 2'd0);
    assign data_o  = mem_r[head_r];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            head_r   <= 1'b0;
            tail_r   <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (enq) begin
                mem_r[tail_r] <= data_i;
                tail_r        <= ~tail_r;
            end
            if (deq) begin
                head_r <= ~head_r;
            end
            count_r <= count_r + 2'(enq) - 2'(deq);
        end
    end

endmodule

// File: rtl/bsg_host_endpoint.sv
// rtl/bsg_host_endpoint.sv - host-side bsg_host link endpoint with credits, response buffer and fault flags
module bsg_host_endpoint
    import bsg_nasti_pkg::*;
#(
    parameter int credits_p = 4,
    parameter int timeout_p = 1024
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           cmd_v_i,
    input  logic [bsg_host_width_p-1:0]    cmd_data_i,
    output logic                           cmd_ready_o,
    output logic                           link_v_o,
    output logic [bsg_host_width_p-1:0]    link_data_o,
    input  logic                           link_ready_i,
    input  logic                           link_v_i,
    input  logic [bsg_host_width_p-1:0]    link_data_i,
    output logic                           link_ready_o,
    output logic                           resp_v_o,
    output logic [bsg_host_width_p-1:0]    resp_data_o,
    input  logic                           resp_yumi_i,
    input  logic                           clear_i,
    output logic                           timeout_o,
    output logic                           unexp_resp_o,
    output logic [$clog2(credits_p+1)-1:0] outstanding_o
);

    localparam int count_w_lp = $clog2(credits_p + 1);
    localparam int timer_w_lp = $clog2(timeout_p + 1);
    localparam logic [count_w_lp-1:0] credits_lp   = count_w_lp'(credits_p);
    localparam logic [timer_w_lp-1:0] timer_hit_lp = timer_w_lp'(timeout_p - 1);
    localparam logic [timer_w_lp-1:0] timer_sat_lp = timer_w_lp'(timeout_p);

    bsg_host_t             cmd_r;
    logic                  link_v_r;
    logic                  ready_en_r;
    logic                  timeout_r;
    logic                  unexp_r;
    logic [count_w_lp-1:0] outstanding_r;
    logic [timer_w_lp-1:0] timer_r;
    logic                  fifo_ready;
    logic                  cmd_accept;
    logic                  resp_enq;
    logic                  timer_hit;
    logic                  unexp_event;

    // ready_en_r keeps both ready outputs low through reset and releases them one cycle later
    assign cmd_ready_o   = ready_en_r & (~link_v_r | link_ready_i) & (outstanding_r < credits_lp);
    assign link_ready_o  = ready_en_r & fifo_ready;
    assign cmd_accept    = cmd_v_i & cmd_ready_o;
    assign resp_enq      = link_v_i & link_ready_o;
    assign timer_hit     = (timer_r == timer_hit_lp);
    assign unexp_event   = resp_enq & (outstanding_r == '0);

    assign link_v_o      = link_v_r;
    assign link_data_o   = cmd_r;
    assign timeout_o     = timeout_r;
    assign unexp_resp_o  = unexp_r;
    assign outstanding_o = outstanding_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_r         <= '0;
            link_v_r      <= 1'b0;
            ready_en_r    <= 1'b0;
            timeout_r     <= 1'b0;
            unexp_r       <= 1'b0;
            outstanding_r <= '0;
            timer_r       <= '0;
        end else begin
            ready_en_r <= 1'b1;
            if (cmd_accept) begin
                link_v_r <= 1'b1;
                cmd_r    <= cmd_data_i;
            end else if (link_ready_i) begin
                link_v_r <= 1'b0;
            end
            if (cmd_accept & ~resp_enq) begin
                outstanding_r <= outstanding_r + count_w_lp'(1);
            end else if (resp_enq & ~cmd_accept & (outstanding_r != '0)) begin
                outstanding_r <= outstanding_r - count_w_lp'(1);
            end
            // timer parks one past the hit value so the timeout event fires once per idle stretch
            if (resp_enq | (outstanding_r == '0)) begin
                timer_r <= '0;
            end else if (timer_r != timer_sat_lp) begin
                timer_r <= timer_r + timer_w_lp'(1);
            end
            timeout_r <= timer_hit | (timeout_r & ~clear_i);
            unexp_r   <= unexp_event | (unexp_r & ~clear_i);
        end
    end

    bsg_two_fifo #(
        .width_p(bsg_host_width_p)
    ) resp_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .ready_o   (fifo_ready),
        .data_i    (link_data_i),
        .v_i       (resp_enq),
        .v_o       (resp_v_o),
        .data_o    (resp_data_o),
        .yumi_i    (resp_yumi_i)
    );

endmodule

// File: tb/tb_bsg_host_endpoint.sv
// tb/tb_bsg_host_endpoint.sv - directed and randomized checks of bsg_host_endpoint against a queue-based model
module tb_bsg_host_endpoint;
    import bsg_nasti_pkg::*;

    localparam int credits_lp = 4;
    localparam int timeout_lp = 8;
    localparam int w_lp       = bsg_host_width_p;

    logic            clk_i = 1'b0;
    logic            reset_n_i = 1'b0;
    logic            cmd_v_i = 1'b0;
    logic [w_lp-1:0] cmd_data_i = '0;
    logic            cmd_ready_o;
    logic            link_v_o;
    logic [w_lp-1:0] link_data_o;
    logic            link_ready_i = 1'b0;
    logic            link_v_i = 1'b0;
    logic [w_lp-1:0] link_data_i = '0;
    logic            link_ready_o;
    logic            resp_v_o;
    logic [w_lp-1:0] resp_data_o;
    logic            resp_yumi_i = 1'b0;
    logic            clear_i = 1'b0;
    logic            timeout_o;
    logic            unexp_resp_o;
    logic [2:0]      outstanding_o;

    bsg_host_endpoint #(
        .credits_p(credits_lp),
        .timeout_p(timeout_lp)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .cmd_v_i       (cmd_v_i),
        .cmd_data_i    (cmd_data_i),
        .cmd_ready_o   (cmd_ready_o),
        .link_v_o      (link_v_o),
        .link_data_o   (link_data_o),
        .link_ready_i  (link_ready_i),
        .link_v_i      (link_v_i),
        .link_data_i   (link_data_i),
        .link_ready_o  (link_ready_o),
        .resp_v_o      (resp_v_o),
        .resp_data_o   (resp_data_o),
        .resp_yumi_i   (resp_yumi_i),
        .clear_i       (clear_i),
        .timeout_o     (timeout_o),
        .unexp_resp_o  (unexp_resp_o),
        .outstanding_o (outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    // reference model: link slot, in-flight count, idle-cycle count, sticky flags, response queue
    bit              m_en;
    bit              m_link_v;
    logic [w_lp-1:0] m_link_data;
    int              m_out;
    int              m_idle;
    bit              m_timeout;
    bit              m_unexp;
    logic [w_lp-1:0] m_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit exp_cmd_ready();
        return m_en && (!m_link_v || link_ready_i) && (m_out < credits_lp);
    endfunction

    function automatic bit exp_link_ready();
        return m_en && (m_q.size() < 2);
    endfunction

    task automatic compare_all();
        check("cmd_ready", 32'(cmd_ready_o), 32'(exp_cmd_ready()));
        check("link_v", 32'(link_v_o), 32'(m_link_v));
        if (m_link_v) check("link_data", link_data_o, m_link_data);
        check("link_ready", 32'(link_ready_o), 32'(exp_link_ready()));
        check("resp_v", 32'(resp_v_o), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("resp_data", resp_data_o, m_q[0]);
        check("timeout", 32'(timeout_o), 32'(m_timeout));
        check("unexp", 32'(unexp_resp_o), 32'(m_unexp));
        check("outstanding", 32'(outstanding_o), 32'(m_out));
    endtask

    task automatic cycle();
        bit acc;
        bit enq;
        bit deq;
        bit fire;
        #1;
        compare_all();
        acc  = cmd_v_i && exp_cmd_ready();
        enq  = link_v_i && exp_link_ready();
        deq  = resp_yumi_i && (m_q.size() != 0);
        fire = (m_idle == timeout_lp - 1);
        @(posedge clk_i);
        m_en = 1'b1;
        if (acc) begin
            m_link_v    = 1'b1;
            m_link_data = cmd_data_i;
        end else if (link_ready_i) begin
            m_link_v = 1'b0;
        end
        if (enq || m_out == 0) m_idle = 0;
        else m_idle++;
        m_unexp = (enq && m_out == 0) || (m_unexp && !clear_i);
        if (acc && !enq) m_out++;
        else if (enq && !acc && m_out > 0) m_out--;
        m_timeout = fire || (m_timeout && !clear_i);
        if (deq) void'(m_q.pop_front());
        if (enq) m_q.push_back(link_data_i);
        #1;
    endtask

    task automatic do_reset();
        #1;
        reset_n_i = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        check("rst_link_v", 32'(link_v_o), 32'd0);
        check("rst_link_data", link_data_o, 32'd0);
        check("rst_link_ready", 32'(link_ready_o), 32'd0);
        check("rst_resp_v", 32'(resp_v_o), 32'd0);
        check("rst_resp_data", resp_data_o, 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_unexp", 32'(unexp_resp_o), 32'd0);
        check("rst_outstanding", 32'(outstanding_o), 32'd0);
        m_en = 0; m_link_v = 0; m_link_data = '0; m_out = 0; m_idle = 0;
        m_timeout = 0; m_unexp = 0; m_q.delete();
        cmd_v_i = 0; link_ready_i = 0; link_v_i = 0; resp_yumi_i = 0; clear_i = 0;
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
    endtask

    initial begin
        // 1: reset mid-traffic
        do_reset();
        cycle();
        link_ready_i = 1; cmd_v_i = 1;
        for (int i = 0; i < 3; i++) begin
            cmd_data_i = 32'h100 + i;
            cycle();
        end
        cmd_v_i = 0; link_ready_i = 0;
        cycle();
        check("t1_link_v_before_reset", 32'(link_v_o), 32'd1);
        check("t1_out_before_reset", 32'(outstanding_o), 32'd3);
        do_reset();
        cycle();
        check("t1_ready_after_release", 32'(cmd_ready_o), 32'd1);

        // 2: credit stall
        link_ready_i = 1; cmd_v_i = 1;
        for (int k = 0; k < 4; k++) begin
            cmd_data_i = 32'hA0 + k;
            cycle();
            check("t2_issue", link_data_o, 32'hA0 + k);
        end
        cmd_data_i = 32'hA4;
        check("t2_stall_ready", 32'(cmd_ready_o), 32'd0);
        cycle();
        cycle();
        check("t2_stall_idle", 32'(link_v_o), 32'd0);
        link_v_i = 1; link_data_i = 32'h0000_7777;
        cycle();
        link_v_i = 0;
        check("t2_ready_after_resp", 32'(cmd_ready_o), 32'd1);
        cycle();
        cmd_v_i = 0;
        check("t2_e_issued", link_data_o, 32'hA4);
        check("t2_e_valid", 32'(link_v_o), 32'd1);
        cycle();

        // 3: backpressure
        do_reset();
        cycle();
        link_ready_i = 0; cmd_v_i = 1; cmd_data_i = 32'hDEAD;
        cycle();
        cmd_data_i = 32'hBEEF;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t3_hold_data", link_data_o, 32'hDEAD);
            check("t3_hold_ready", 32'(cmd_ready_o), 32'd0);
        end
        link_ready_i = 1; cmd_v_i = 0;
        cycle();
        check("t3_once", 32'(link_v_o), 32'd0);
        cycle();

        // 4: response buffering
        do_reset();
        cycle();
        link_ready_i = 1; cmd_v_i = 1;
        for (int i = 0; i < 3; i++) begin
            cmd_data_i = 32'h200 + i;
            cycle();
        end
        cmd_v_i = 0;
        link_v_i = 1; link_data_i = 32'h5151_0001;
        cycle();
        link_data_i = 32'h5151_0002;
        cycle();
        check("t4_full_ready", 32'(link_ready_o), 32'd0);
        link_data_i = 32'h5151_0003;
        cycle();
        check("t4_r3_refused", 32'(link_ready_o), 32'd0);
        check("t4_head_r1", resp_data_o, 32'h5151_0001);
        resp_yumi_i = 1;
        cycle();
        check("t4_head_r2", resp_data_o, 32'h5151_0002);
        cycle();
        link_v_i = 0;
        check("t4_head_r3", resp_data_o, 32'h5151_0003);
        cycle();
        resp_yumi_i = 0;
        check("t4_drained", 32'(resp_v_o), 32'd0);

        // 5: timeout
        do_reset();
        cycle();
        link_ready_i = 1; cmd_v_i = 1; cmd_data_i = 32'h300;
        cycle();
        cmd_v_i = 0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            check("t5_timeout", 32'(timeout_o), 32'(k >= 8));
        end
        clear_i = 1;
        cycle();
        clear_i = 0;
        check("t5_cleared", 32'(timeout_o), 32'd0);
        for (int k = 0; k < 3; k++) cycle();
        check("t5_stays_clear", 32'(timeout_o), 32'd0);
        link_v_i = 1; link_data_i = 32'h3030;
        cycle();
        link_v_i = 0;
        check("t5_out_zero", 32'(outstanding_o), 32'd0);

        // 6: unexpected response
        do_reset();
        cycle();
        link_v_i = 1; link_data_i = 32'hFACE;
        cycle();
        link_v_i = 0;
        check("t6_unexp", 32'(unexp_resp_o), 32'd1);
        check("t6_out", 32'(outstanding_o), 32'd0);
        check("t6_resp_v", 32'(resp_v_o), 32'd1);
        check("t6_resp_data", resp_data_o, 32'hFACE);

        // randomized traffic
        do_reset();
        cycle();
        for (int n = 0; n < 3000; n++) begin
            cmd_v_i      = ($urandom_range(0, 1) == 1);
            cmd_data_i   = $urandom();
            link_ready_i = ($urandom_range(0, 3) != 0);
            link_v_i     = ($urandom_range(0, 2) == 0);
            link_data_i  = $urandom();
            resp_yumi_i  = (m_q.size() != 0) && ($urandom_range(0, 1) == 1);
            clear_i      = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
